// File: rtl/loader_pkg.sv
// Shared types and defaults for the program loader.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents:
//   LD_WORD_SIZE       data nibble width, kept equal to the shared WORD_SIZE define
//   LD_ADDR_WIDTH      instruction/data memory address width (16 words)
//   LD_TIMEOUT_CYCLES  default idle budget between nibbles once a load has started
//   state_t            loader FSM states
//   is_loading()       true in the states where the image stream is being consumed
package loader_pkg;

  localparam int LD_WORD_SIZE      = 4;
  localparam int LD_ADDR_WIDTH     = 4;
  localparam int LD_TIMEOUT_CYCLES = 255;

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    DATA = 3'd1,
    CHK  = 3'd2,
    RUN  = 3'd3,
    FAIL = 3'd4
  } state_t;

  // DATA and CHK are the phases where busy is high and the idle timer runs.
  function automatic logic is_loading(input state_t s);
    return (s == DATA) || (s == CHK);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog for the loader stream.
// Latency: expired is combinational from the counter and the clear/enable inputs.
// Backpressure: none; the counter only observes handshake activity.
//
// Ports:
//   clk, reset   clock and synchronous active-low reset
//   clear        a handshake happened this cycle (or the timer is not in use)
//   enable       the loader is in a phase where idle time is limited
//   expired      this is the TIMEOUT_CYCLES-th consecutive idle cycle
module loader_timeout
  import loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LD_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // The count never needs to exceed TIMEOUT_CYCLES-1: the loader leaves the
  // timed phase in the same cycle expired is raised.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_IDLE = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear || !enable) begin
      r_count <= '0;
    end else if (!expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  // r_count holds the number of idle cycles already elapsed; when it reads
  // TIMEOUT_CYCLES-1 and this cycle is idle too, the budget is used up.
  assign expired = enable && !clear && (r_count == LAST_IDLE);

endmodule

// File: rtl/program_loader.sv
// Loads a header/data/checksum nibble stream into the 16-word memory and releases the CPU on a good checksum.
// Latency: memory write 1 cycle after each data handshake; cpu_run 1 cycle after the checksum handshake.
// Backpressure: in_ready is low outside HDR/DATA/CHK and whenever load_req is high; the write port has none.
//
// Ports:
//   clk, reset          clock and synchronous active-low reset
//   in_data/in_valid    stream nibble and its qualifier
//   in_ready            loader takes a nibble this cycle
//   load_req            abort anything in progress and wait for a new header
//   mem_we/addr/wdata   registered one-cycle memory write port
//   cpu_run             high releases the CPU
//   busy                high while consuming data or checksum
//   error               sticky failure flag, cleared by the next header
module program_loader
  import loader_pkg::*;
#(
  parameter int WORD_SIZE      = LD_WORD_SIZE,
  parameter int ADDR_WIDTH     = LD_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = LD_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_SIZE-1:0]  in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  load_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  output logic                  cpu_run,
  output logic                  busy,
  output logic                  error
);

  state_t r_state;
  state_t w_next_state;

  // Words still to come minus one; reaching zero on a data handshake means
  // the last word of the image has just been taken.
  logic [WORD_SIZE-1:0]  r_remaining;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_SIZE-1:0]  r_acc;
  logic                  r_error;

  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [WORD_SIZE-1:0]  r_mem_wdata;

  logic w_accepting;
  logic w_xfer;
  logic w_loading;
  logic w_expired;

  // in_ready depends only on state and load_req, never on in_valid, so the
  // handshake can be formed here without a combinational loop.
  assign w_accepting = ((r_state == HDR) || is_loading(r_state)) && !load_req;
  assign w_xfer      = in_valid && w_accepting;
  assign w_loading   = is_loading(r_state);

  loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_xfer),
    .enable  (w_loading),
    .expired (w_expired)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= HDR;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    cpu_run      = 1'b0;
    busy         = 1'b0;

    unique case (r_state)
      HDR: begin
        if (w_xfer) w_next_state = DATA;
      end
      DATA: begin
        busy = 1'b1;
        if (w_xfer) begin
          if (r_remaining == '0) w_next_state = CHK;
        end else if (w_expired) begin
          w_next_state = FAIL;
        end
      end
      CHK: begin
        busy = 1'b1;
        if (w_xfer) begin
          w_next_state = (in_data == r_acc) ? RUN : FAIL;
        end else if (w_expired) begin
          w_next_state = FAIL;
        end
      end
      RUN: begin
        cpu_run = 1'b1;
      end
      FAIL: begin
        w_next_state = HDR;
      end
      default: begin
        w_next_state = HDR;
      end
    endcase

    // An abort overrides every other transition.
    if (load_req) w_next_state = HDR;
  end

  // ---------------------------------------------------------------------------
  // Datapath: count, address, checksum, error flag and the write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_remaining <= '0;
      r_addr      <= '0;
      r_acc       <= '0;
      r_error     <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= 1'b0;

      // FAIL lasts one cycle; latch the sticky flag on the way out so it
      // survives into HDR and through any abort.
      if (r_state == FAIL) r_error <= 1'b1;

      if (w_xfer) begin
        unique case (r_state)
          HDR: begin
            r_remaining <= in_data;
            r_addr      <= '0;
            r_acc       <= '0;
            r_error     <= 1'b0;
          end
          DATA: begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= in_data;
            // For a 16-word image this wraps to 0 on the last word, which is
            // harmless because the count moves the FSM to CHK first.
            r_addr      <= r_addr + 1'b1;
            r_acc       <= r_acc + in_data;
            r_remaining <= r_remaining - 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign in_ready  = w_accepting;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  // FAIL is visible on error in the very cycle it is entered.
  assign error     = r_error || (r_state == FAIL);

endmodule

// File: doc/program_loader.md
# program_loader

Writes a program image into the 16-word instruction/data memory and holds the CPU halted until the image is complete and verified. The image arrives as a nibble stream over a valid/ready handshake: header, data, checksum. The block drives the memory unit's write port and releases the CPU through `cpu_run` only after the checksum passes. It sits beside `system`, between a host or debug link and the memory unit and control path.

## Interface
Parameters:
- `WORD_SIZE`, 4, data nibble width; equals the shared `WORD_SIZE` define.
- `ADDR_WIDTH`, 4, memory address width; depth is 2**ADDR_WIDTH = 16.
- `TIMEOUT_CYCLES`, 255, maximum idle cycles between nibbles once a load has started.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-low. One clock; all state is sampled on the rising edge of `clk`.
- `in_data`  in  WORD_SIZE  stream nibble.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a nibble this cycle.
- `load_req`  in  1  level or pulse; aborts any load or run and restarts at header.
- `mem_we`  out  1  one-cycle memory write strobe.
- `mem_addr`  out  ADDR_WIDTH  write address.
- `mem_wdata`  out  WORD_SIZE  write data.
- `cpu_run`  out  1  high releases the CPU; low holds it halted.
- `busy`  out  1  a load is in progress (past the header).
- `error`  out  1  sticky: last load failed on checksum or timeout.

## Operation
- Handshake: a nibble transfers when `in_valid && in_ready` at a rising edge. `in_ready = (state ∈ {HDR, DATA, CHK}) && !load_req`, combinational from state and `load_req`.
- States and transitions:
  - HDR: accept the header nibble H, which means N = H+1 words (1..16). Latch the remaining count, clear the address counter and checksum accumulator, clear `error`, go to DATA.
  - DATA: each accepted nibble is written to the current address. Address increments; the accumulator adds the nibble mod 16. After the N-th nibble, go to CHK.
  - CHK: accept the checksum nibble C. If C == accumulator, go to RUN; otherwise go to FAIL.
  - RUN: `cpu_run` is 1. Stays in RUN until `load_req`.
  - FAIL: one cycle long. Sets `error`, then goes to HDR.
- Timeout: a counter runs in DATA and CHK and clears on every handshake. Reaching TIMEOUT_CYCLES with no handshake moves the block to FAIL. The counter does not run in HDR or RUN.
- `load_req` high in any state: next state is HDR, `cpu_run` goes to 0, and any partially loaded image is abandoned. Memory contents already written are left as they are. `error` is not cleared; only a new header clears it.
- Writes to all 16 addresses (H = 0xF) wrap the address counter to 0 with no effect, because the count ends the phase first.
- Memory always accepts a write; there is no back-pressure on the write port.

## Timing
- Reset values: state = HDR, `in_ready` = 1 (unless `load_req` is high), `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `cpu_run` = 0, `busy` = 0, `error` = 0.
- `mem_we`, `mem_addr` and `mem_wdata` are registered. The write strobe appears exactly 1 cycle after the data handshake, and `mem_we` is high for one cycle per nibble. Back-to-back nibbles produce consecutive write cycles.
- `cpu_run` rises 1 cycle after the checksum handshake, and only when the checksum matches. It falls 1 cycle after `load_req` is sampled high.
- `error` rises the cycle the block enters FAIL. It clears 1 cycle after a header handshake.
- `busy` is high in DATA and CHK.
- Reset asserted mid-load: every output returns to its reset value at the next edge, and no `mem_we` issues after that edge.

## Structure
- Shared package `loader_pkg` holds the state enum (`HDR`, `DATA`, `CHK`, `RUN`, `FAIL`) and the default TIMEOUT_CYCLES.
- `WORD_SIZE` comes from `defines.vh`.
- One sub-module, `loader_timeout`: the idle counter, with inputs `clear` and `enable` and output `expired`.
- The FSM, address counter, count and checksum accumulator live in `program_loader`.
- `system` integration: `cpu_run` gates the control unit's `ce`, and the memory write port is muxed in while `cpu_run` is 0.

## Test plan
- Nominal load: send H=0x2, then 0x1, 0xE, 0x5, then C=0x4. Expect writes [0]=1, [1]=E, [2]=5, each 1 cycle after its handshake. `cpu_run` goes to 1 one cycle after C; `error` stays 0.
- Bad checksum: same stream with C=0x5. Expect 3 writes, `cpu_run` stays 0, `error`=1, state returns to HDR with `in_ready`=1.
- Full image with stalls: H=0xF, 16 nibbles 0x0..0xF with `in_valid` dropped for 3 cycles between nibbles, then C=0x8 (sum 120 mod 16). Expect addresses 0..15 written, no 17th write, `cpu_run`=1.
- Timeout: H=0x3, two data nibbles, then `in_valid` held 0 for 255 cycles. Expect `error`=1 and HDR after the timeout, and no further writes.
- Abort and reload: `load_req` pulsed in the middle of DATA, and again in RUN. Expect `in_ready`=0 while `load_req` is high, `cpu_run` low 1 cycle after the pulse, and a new header accepted on the next handshake.
- Reset mid-load: `reset`=0 for one cycle after the 2nd data nibble. Expect all outputs at reset values and the pending write suppressed.
